reorder_buffer_commit: RTL and testbench
========================================

Name: reorder_buffer_commit

Overview:
- In-order retirement buffer that produces the commit interface consumed by the rename/free-list stage.
- Dispatch allocates one entry per renamed instruction, in program order. Execution marks entries done by ROB id, in any order.
- Retires at most one entry per cycle from the head: drives commit_valid, commit_with_write and commited_wr_register.
- Sits between the rename stage and the writeback/completion bus.

Parameters:
- ROB_ADDR_WIDTH, 4, log2 of entry count (DEPTH = 1<<ROB_ADDR_WIDTH).
- ARCH_REG_NUM_WIDTH, `ARCH_REG_NUM_WIDTH, width of architectural register number.
- PHYSICAL_REG_NUM_WIDTH, `PHYSICAL_REG_NUM_WIDTH, width of physical register number.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- alloc_valid  input  1  dispatch requests an entry this cycle.
- alloc_with_write  input  1  instruction writes a destination register.
- alloc_phy_wr_reg  input  PHYSICAL_REG_NUM_WIDTH  newly mapped physical destination.
- alloc_arch_wr_reg  input  ARCH_REG_NUM_WIDTH  architectural destination.
- alloc_ready  output  1  an entry is free; alloc fires when alloc_valid && alloc_ready.
- alloc_rob_id  output  ROB_ADDR_WIDTH  id the entry will receive (current tail).
- cmpl_valid  input  1  an instruction finished execution.
- cmpl_rob_id  input  ROB_ADDR_WIDTH  id of the finished entry.
- commit_valid  output  1  head entry retires this cycle.
- commit_with_write  output  1  retiring entry has a destination.
- commited_wr_register  output  PHYSICAL_REG_NUM_WIDTH  physical destination of the retiring entry.
- commited_arch_reg  output  ARCH_REG_NUM_WIDTH  architectural destination of the retiring entry.
- rob_count  output  ROB_ADDR_WIDTH+1  occupied entries, 0..DEPTH.

Behaviour:
- Per-entry state: FREE, WAITING, DONE.
  - FREE -> WAITING on alloc fire at the tail.
  - WAITING -> DONE on cmpl_valid with a matching id.
  - DONE -> FREE on commit at the head.
- Pointers:
  - head and tail are ROB_ADDR_WIDTH-bit and wrap modulo DEPTH.
  - count is held separately to disambiguate full from empty.
- alloc_ready = (count < DEPTH), from registered count only. No same-cycle bypass from a commit, so a full buffer accepts nothing even while committing.
- alloc_rob_id = tail, combinational.
- On alloc fire, the entry stores with_write, phy and arch fields, and tail increments.
- Completion:
  - Ignored if the target entry is FREE or already DONE; no state change.
  - Completion does not need to arrive in id order.
- Commit:
  - commit_valid = (state[head] == DONE), combinational from registers.
  - Other commit outputs come from the head entry.
  - commit_with_write and the register fields are forced to 0 when commit_valid = 0.
  - The consumer has no back-pressure: commit fires whenever commit_valid = 1. At the clock edge, the head entry goes to FREE and head increments.
- Latency:
  - Alloc at edge N, entry visible as WAITING after N.
  - Completion sampled at edge M sets DONE; commit_valid rises in cycle M+1 if the entry is at the head.
  - Minimum alloc-to-commit is 2 cycles.
- Simultaneous events:
  - Alloc and commit in the same cycle: count unchanged, both pointers advance.
  - Completion for the head in the same cycle as a commit of a different entry is impossible, since the head is unique.
  - Completion for an entry being allocated that cycle is ignored, since the entry is FREE when sampled.
- Wrap: tail DEPTH-1 -> 0 and head DEPTH-1 -> 0 without gaps.
- Reset (asynchronous, mid-operation included), all entries discarded:
  - All entries FREE; head = tail = 0; count = 0.
  - alloc_ready = 1, alloc_rob_id = 0.
  - commit_valid = 0, commit_with_write = 0, commited_wr_register = 0, commited_arch_reg = 0, rob_count = 0.

Decomposition:
- Shared package rob_pkg holds:
  - rob_state_e enum (FREE, WAITING, DONE).
  - rob_entry_t struct (state, with_write, phy_wr_reg, arch_wr_reg).
  - ROB_DEPTH localparam derived from ROB_ADDR_WIDTH.
- No sub-module. Entry array, pointers and counter live in one module with one always_comb block and one always_ff block.

Test Plan:
- Reset, then alloc 3 entries (phy 32, 33, 34, with_write = 1); complete id 0 -> commit_valid = 1 for one cycle with commited_wr_register = 32, then idle because ids 1 and 2 are WAITING.
- Complete ids 2 then 1 out of order -> commits in order: 33, then 34, on consecutive cycles.
- Fill 16 entries -> alloc_ready = 0 and rob_count = 16. Alloc and commit in the same cycle while full -> alloc not accepted. The next cycle, alloc_ready = 1 and the new entry is accepted at id 0 (wrap).
- Allocate with alloc_with_write = 0, then complete it -> commit_valid = 1, commit_with_write = 0, commited_wr_register = 0.
- Completion to a FREE id (id 5 with ROB empty) and a duplicate completion -> no commit, rob_count unchanged.
- Assert reset low with 7 entries in flight, 3 DONE -> commit_valid = 0 and rob_count = 0 immediately. After release, the first alloc gets id 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry lifecycle state and per-entry payload.
package rob_pkg;

    localparam int ROB_ADDR_W = 4;
    localparam int ROB_DEPTH  = 1 << ROB_ADDR_W;
    localparam int ARCH_REG_W = 5;
    localparam int PHY_REG_W  = 6;

    typedef enum logic [1:0] {
        ROB_FREE    = 2'd0,
        ROB_WAITING = 2'd1,
        ROB_DONE    = 2'd2
    } rob_state_e;

    typedef struct packed {
        rob_state_e            state;
        logic                  with_write;
        logic [PHY_REG_W-1:0]  phy_wr_reg;
        logic [ARCH_REG_W-1:0] arch_wr_reg;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_commit.sv
// In-order retirement buffer: allocate at tail, complete by id, retire one per cycle
// from the head toward the rename/free-list stage.
module reorder_buffer_commit
    import rob_pkg::*;
#(
    parameter int ROB_ADDR_WIDTH         = ROB_ADDR_W,
    parameter int ARCH_REG_NUM_WIDTH     = ARCH_REG_W,
    parameter int PHYSICAL_REG_NUM_WIDTH = PHY_REG_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid,
    input  logic                              alloc_with_write,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_wr_reg,
    input  logic [ARCH_REG_NUM_WIDTH-1:0]     alloc_arch_wr_reg,
    output logic                              alloc_ready,
    output logic [ROB_ADDR_WIDTH-1:0]         alloc_rob_id,
    input  logic                              cmpl_valid,
    input  logic [ROB_ADDR_WIDTH-1:0]         cmpl_rob_id,
    output logic                              commit_valid,
    output logic                              commit_with_write,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
    output logic [ARCH_REG_NUM_WIDTH-1:0]     commited_arch_reg,
    output logic [ROB_ADDR_WIDTH:0]           rob_count
);

    localparam int DEPTH = 1 << ROB_ADDR_WIDTH;
    localparam int CNT_W = ROB_ADDR_WIDTH + 1;

    rob_entry_t                entries_q [DEPTH];
    rob_entry_t                entries_d [DEPTH];
    logic [ROB_ADDR_WIDTH-1:0] head_q, head_d;
    logic [ROB_ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;
    rob_entry_t                head_e;
    logic                      alloc_fire;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        // Registered count only: a full buffer stays closed even while retiring.
        alloc_ready  = count_q < CNT_W'(DEPTH);
        alloc_fire   = alloc_valid && alloc_ready;
        alloc_rob_id = tail_q;
        rob_count    = count_q;

        head_e            = entries_q[head_q];
        commit_valid      = head_e.state == ROB_DONE;
        commit_with_write = commit_valid && head_e.with_write;
        commited_wr_register = commit_with_write ? head_e.phy_wr_reg  : '0;
        commited_arch_reg    = commit_with_write ? head_e.arch_wr_reg : '0;

        if (cmpl_valid && entries_q[cmpl_rob_id].state == ROB_WAITING) begin
            entries_d[cmpl_rob_id].state = ROB_DONE;
        end

        if (commit_valid) begin
            entries_d[head_q].state = ROB_FREE;
            head_d = head_q + 1'b1;
        end

        // Tail is never the committing head here: alloc needs count < DEPTH.
        if (alloc_fire) begin
            entries_d[tail_q] = '{
                state:       ROB_WAITING,
                with_write:  alloc_with_write,
                phy_wr_reg:  alloc_phy_wr_reg,
                arch_wr_reg: alloc_arch_wr_reg
            };
            tail_d = tail_q + 1'b1;
        end

        unique case ({alloc_fire, commit_valid})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer_commit.sv
// Directed bench for reorder_buffer_commit with an in-order commit scoreboard.
module tb_reorder_buffer_commit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_valid;
    logic       alloc_with_write;
    logic [5:0] alloc_phy_wr_reg;
    logic [4:0] alloc_arch_wr_reg;
    logic       alloc_ready;
    logic [3:0] alloc_rob_id;
    logic       cmpl_valid;
    logic [3:0] cmpl_rob_id;
    logic       commit_valid;
    logic       commit_with_write;
    logic [5:0] commited_wr_register;
    logic [4:0] commited_arch_reg;
    logic [4:0] rob_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       wr;
        logic [5:0] phy;
        logic [4:0] arch;
    } exp_t;

    exp_t exp_q[$];
    int   ms[16];
    int   mhead, mtail, mcount;

    reorder_buffer_commit dut (
        .clk                  (clk),
        .reset                (rst_n),
        .alloc_valid          (alloc_valid),
        .alloc_with_write     (alloc_with_write),
        .alloc_phy_wr_reg     (alloc_phy_wr_reg),
        .alloc_arch_wr_reg    (alloc_arch_wr_reg),
        .alloc_ready          (alloc_ready),
        .alloc_rob_id         (alloc_rob_id),
        .cmpl_valid           (cmpl_valid),
        .cmpl_rob_id          (cmpl_rob_id),
        .commit_valid         (commit_valid),
        .commit_with_write    (commit_with_write),
        .commited_wr_register (commited_wr_register),
        .commited_arch_reg    (commited_arch_reg),
        .rob_count            (rob_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic wr, input logic [5:0] phy,
                            input logic [4:0] arch);
        alloc_valid       = 1'b1;
        alloc_with_write  = wr;
        alloc_phy_wr_reg  = phy;
        alloc_arch_wr_reg = arch;
        cyc();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cmpl(input logic [3:0] id);
        cmpl_valid  = 1'b1;
        cmpl_rob_id = id;
        cyc();
        cmpl_valid = 1'b0;
    endtask

    // Reference model sampled mid-cycle; inputs are stable until the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) ms[i] = 0;
            mhead  = 0;
            mtail  = 0;
            mcount = 0;
            exp_q.delete();
        end else begin
            logic exp_cv;
            logic fire;
            exp_t e;
            exp_cv = (ms[mhead] == 2);
            fire   = alloc_valid && (mcount < 16);
            chk("m_cv", commit_valid, exp_cv);
            chk("m_ready", alloc_ready, mcount < 16);
            chk("m_count", rob_count, mcount);
            chk("m_rob_id", alloc_rob_id, mtail);
            if (exp_cv) begin
                if (exp_q.size() == 0) begin
                    chk("m_q_empty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_wr", commit_with_write, e.wr);
                    chk("m_phy", commited_wr_register, e.wr ? e.phy : 6'd0);
                    chk("m_arch", commited_arch_reg, e.wr ? e.arch : 5'd0);
                end
            end else begin
                chk("m_idle_wr", commit_with_write, 0);
                chk("m_idle_phy", commited_wr_register, 0);
            end
            if (cmpl_valid && ms[cmpl_rob_id] == 1) ms[cmpl_rob_id] = 2;
            if (exp_cv) begin
                ms[mhead] = 0;
                mhead = (mhead + 1) % 16;
                mcount--;
            end
            if (fire) begin
                ms[mtail] = 1;
                exp_q.push_back('{alloc_with_write, alloc_phy_wr_reg,
                                  alloc_arch_wr_reg});
                mtail = (mtail + 1) % 16;
                mcount++;
            end
        end
    end

    initial begin
        rst_n             = 1'b0;
        alloc_valid       = 1'b0;
        alloc_with_write  = 1'b0;
        alloc_phy_wr_reg  = '0;
        alloc_arch_wr_reg = '0;
        cmpl_valid        = 1'b0;
        cmpl_rob_id       = '0;
        repeat (2) cyc();
        chk("rst_cv", commit_valid, 0);
        chk("rst_cnt", rob_count, 0);
        chk("rst_rdy", alloc_ready, 1);
        chk("rst_id", alloc_rob_id, 0);
        chk("rst_phy", commited_wr_register, 0);
        chk("rst_arch", commited_arch_reg, 0);
        rst_n = 1'b1;
        cyc();

        do_alloc(1'b1, 6'd32, 5'd1);
        do_alloc(1'b1, 6'd33, 5'd2);
        do_alloc(1'b1, 6'd34, 5'd3);
        do_cmpl(4'd0);
        chk("c0_v", commit_valid, 1);
        chk("c0_phy", commited_wr_register, 32);
        cyc();
        chk("hold_v", commit_valid, 0);
        do_cmpl(4'd2);
        chk("ooo_v", commit_valid, 0);
        do_cmpl(4'd1);
        chk("c1_phy", commited_wr_register, 33);
        cyc();
        chk("c2_phy", commited_wr_register, 34);
        cyc();
        chk("drain_cnt", rob_count, 0);

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_alloc(1'b1, 6'(16 + i), 5'(i));
        end
        chk("full_rdy", alloc_ready, 0);
        chk("full_cnt", rob_count, 16);
        do_cmpl(4'd0);
        alloc_valid       = 1'b1;
        alloc_with_write  = 1'b1;
        alloc_phy_wr_reg  = 6'd50;
        alloc_arch_wr_reg = 5'd9;
        chk("full_cv", commit_valid, 1);
        chk("full_blk", alloc_ready, 0);
        cyc();
        chk("wrap_rdy", alloc_ready, 1);
        chk("wrap_id", alloc_rob_id, 0);
        chk("wrap_cnt", rob_count, 15);
        cyc();
        alloc_valid = 1'b0;
        chk("refill_cnt", rob_count, 16);
        for (int i = 1; i < 16; i++) begin
            do_cmpl(4'(i));
        end
        do_cmpl(4'd0);
        chk("wrap_phy", commited_wr_register, 50);
        cyc();
        chk("empty_cnt", rob_count, 0);

        do_alloc(1'b0, 6'd45, 5'd7);
        do_cmpl(4'd1);
        chk("nw_v", commit_valid, 1);
        chk("nw_wr", commit_with_write, 0);
        chk("nw_phy", commited_wr_register, 0);
        cyc();

        do_cmpl(4'd5);
        chk("free_v", commit_valid, 0);
        chk("free_cnt", rob_count, 0);

        do_alloc(1'b1, 6'd20, 5'd1);
        do_alloc(1'b1, 6'd21, 5'd2);
        do_cmpl(4'd3);
        do_cmpl(4'd3);
        chk("dup_v", commit_valid, 0);
        chk("dup_cnt", rob_count, 2);
        do_cmpl(4'd2);
        chk("dup_c0", commited_wr_register, 20);
        cyc();
        chk("dup_c1", commited_wr_register, 21);
        cyc();
        do_cmpl(4'd3);
        chk("late_v", commit_valid, 0);
        chk("late_cnt", rob_count, 0);

        for (int i = 0; i < 7; i++) begin
            do_alloc(1'b1, 6'(40 + i), 5'(i));
        end
        do_cmpl(4'd6);
        do_cmpl(4'd7);
        do_cmpl(4'd4);
        chk("pre_rst_v", commit_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", commit_valid, 0);
        chk("mid_rst_cnt", rob_count, 0);
        chk("mid_rst_rdy", alloc_ready, 1);
        chk("mid_rst_id", alloc_rob_id, 0);
        cyc();
        rst_n = 1'b1;
        chk("post_id", alloc_rob_id, 0);
        do_alloc(1'b1, 6'd60, 5'd2);
        do_cmpl(4'd0);
        chk("post_phy", commited_wr_register, 60);
        repeat (2) cyc();
        chk("post_cnt", rob_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
